// File: rtl/sr_latch_driver.sv
// sr_latch_driver: debounced pushbuttons to clean, mutually exclusive S/R pulses for a NOR SR latch
module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic Q_model
);
  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_t;
  logic [1:0] btn, req;
  state_t state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
  logic conflict_q, conflict_d, q_q, q_d;
  logic set_any, rst_any;
  assign btn = {reset_btn, set_btn};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic s1_q, s2_q, deb_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic hit;
    assign hit = (cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_CYCLES);
    // sync the raw button, debounce the synced level, keep last level for edge detect
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        deb_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= btn[c];
        s2_q   <= s1_q;
        prev_q <= deb_q;
        if (s2_q == deb_q) begin
          cnt_q <= '0;
        end else if (hit) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
    assign req[c] = deb_q & ~prev_q;
  end
  // a fresh request is seen in IDLE the same cycle it appears, so no extra pending-flag latency
  assign set_any = set_pend_q | req[0];
  assign rst_any = rst_pend_q | req[1];
  // pulse sequencing, request merging and conflict discard
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    set_pend_d = set_any;
    rst_pend_d = rst_any;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        set_pend_d = 1'b0;
        rst_pend_d = 1'b0;
        conflict_d = set_any & rst_any;
        pcnt_d     = 4'(PULSE_CYCLES - 1);
        state_d    = conflict_d ? IDLE : set_any ? DRIVE_S : rst_any ? DRIVE_R : IDLE;
      end
      DRIVE_S, DRIVE_R: begin
        pcnt_d  = pcnt_q - 4'd1;
        state_d = (pcnt_q == 4'd0) ? GAP : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign q_d = (state_d == DRIVE_S) ? 1'b1 : (state_d == DRIVE_R) ? 1'b0 : q_q;
  // state, counters, pending flags and shadow latch state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      conflict_q <= conflict_d;
      q_q        <= q_d;
    end
  end
  assign S        = state_q == DRIVE_S;
  assign R        = state_q == DRIVE_R;
  assign busy     = state_q != IDLE;
  assign conflict = conflict_q;
  assign Q_model  = q_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: scoreboard bench for sr_latch_driver pulse timing, exclusivity and shadow state
module tb_sr_latch_driver;
  logic clk = 1'b0, reset = 1'b1, set_btn = 1'b0, reset_btn = 1'b0;
  logic S, R, busy, conflict, Q_model;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int kind; int cyc; logic q; int len;} ev_t;
  ev_t exp_q[$];
  ev_t cur;
  logic [2:0] sig, prev_sig = 3'b000;
  int run_len = 0;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;
  sr_latch_driver dut (
    .clk(clk), .reset(reset), .set_btn(set_btn), .reset_btn(reset_btn),
    .S(S), .R(R), .busy(busy), .conflict(conflict), .Q_model(Q_model)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int kind, input int at, input logic q, input int len);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.q    = q;
    e.len  = len;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    sig = {conflict, R, S};
    if (S && R) chk("s_r_exclusive", 1, 0);
    if ((S || R) && !busy) chk("busy_during_pulse", 0, 1);
    if (sig != 3'b000 && prev_sig == 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(sig), 0);
      end else begin
        cur = exp_q.pop_front();
        chk("pulse_kind", sig[0] ? 0 : sig[1] ? 1 : 2, cur.kind);
        chk("pulse_start", cyc, cur.cyc);
        chk("q_model_at_pulse", int'(Q_model), int'(cur.q));
      end
      run_len = 1;
    end else if (sig != 3'b000) begin
      run_len++;
    end else if (prev_sig != 3'b000) begin
      chk("pulse_len", run_len, cur.len);
    end
    prev_sig = sig;
  end
  initial begin
    int c0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conflict", int'(conflict), 0);
    chk("rst_Q", int'(Q_model), 0);
    repeat (50) tick();
    set_btn = 1'b1;
    push(0, cyc + LAT, 1'b1, 2);
    repeat (20) tick();
    set_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_set", int'(Q_model), 1);
    reset_btn = 1'b1;
    push(1, cyc + LAT, 1'b0, 2);
    repeat (10) tick();
    reset_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_reset", int'(Q_model), 0);
    set_btn = 1'b1;
    repeat (3) tick();
    set_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_glitch3", int'(Q_model), 0);
    set_btn = 1'b1;
    push(0, cyc + LAT, 1'b1, 2);
    repeat (4) tick();
    set_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_press4", int'(Q_model), 1);
    set_btn = 1'b1;
    reset_btn = 1'b1;
    push(2, cyc + LAT, 1'b1, 1);
    repeat (10) tick();
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_conflict", int'(Q_model), 1);
    chk("busy_after_conflict", int'(busy), 0);
    c0 = cyc;
    set_btn = 1'b1;
    push(0, c0 + LAT, 1'b1, 2);
    repeat (2) tick();
    reset_btn = 1'b1;
    push(1, c0 + LAT + 4, 1'b0, 2);
    repeat (10) tick();
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (20) tick();
    chk("q_after_back2back", int'(Q_model), 0);
    c0 = cyc;
    set_btn = 1'b1;
    push(0, c0 + LAT, 1'b1, 2);
    tick();
    reset_btn = 1'b1;
    repeat (7) tick();
    chk("midreset_S_before", int'(S), 1);
    reset = 1'b1;
    set_btn = 1'b0;
    reset_btn = 1'b0;
    tick();
    chk("midreset_S", int'(S), 0);
    chk("midreset_R", int'(R), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_Q", int'(Q_model), 0);
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("q_after_midreset", int'(Q_model), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
